// File: rtl/axis_msg_pkg.sv
// Shared types and helpers for the AXI-Stream message source.
package axis_msg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Address/length width for a RAM of the given depth (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_msg_ram.sv
// DEPTH x WIDTH message register file: one synchronous write port, one combinational read port.
module axis_msg_ram
    import axis_msg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the message RAM must read back as zero after reset, so it is a resettable flop array rather than an inferred block RAM.
    // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_msg_source.sv
// AXI-Stream message source: host-loaded RAM streamed as msg_len+1 beats with tlast on the final beat.
// Optional gapless repeat mode when AXIS_MSG_LOOP_EN is defined.
module axis_msg_source
    import axis_msg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    msg_len,
    input  logic             start,
    input  logic             stop_req,
    output logic             busy,
    output logic             done,
    output logic             wr_drop,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready
);

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    len_q, len_d;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_drop_q, wr_drop_d;

    logic             ram_we;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] beat0;
    logic             restart;

`ifdef AXIS_MSG_LOOP_EN
    logic loop_stop_q, loop_stop_d;
    assign restart = !(loop_stop_q || stop_req);
`else
    logic unused_stop_req;
    assign unused_stop_req = stop_req;
    assign restart         = 1'b0;
`endif

    axis_msg_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_drop_d = wr_en && (state_q == ST_SEND);
        ram_we    = wr_en && (state_q == ST_IDLE);
`ifdef AXIS_MSG_LOOP_EN
        loop_stop_d = loop_stop_q;
`endif
        // Read port looks one beat ahead; it points at word 0 whenever the next beat starts a pass.
        rd_addr = (state_q == ST_SEND && !tlast_q) ? idx_q + AW'(1) : '0;
        beat0   = (ram_we && wr_addr == '0) ? wr_data : rd_data;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SEND;
                    len_d    = msg_len;
                    idx_d    = '0;
                    tdata_d  = beat0;
                    tvalid_d = 1'b1;
                    tlast_d  = (msg_len == '0);
                    busy_d   = 1'b1;
`ifdef AXIS_MSG_LOOP_EN
                    loop_stop_d = 1'b0;
`endif
                end
            end
            ST_SEND: begin
`ifdef AXIS_MSG_LOOP_EN
                if (stop_req) begin
                    loop_stop_d = 1'b1;
                end
`endif
                if (tvalid_q && m_axis_tready) begin
                    if (!tlast_q) begin
                        idx_d   = rd_addr;
                        tdata_d = rd_data;
                        tlast_d = (rd_addr == len_q);
                    end else if (restart) begin
                        idx_d   = '0;
                        tdata_d = rd_data;
                        tlast_d = (len_q == '0);
                    end else begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_drop_q <= 1'b0;
`ifdef AXIS_MSG_LOOP_EN
            loop_stop_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_drop_q <= wr_drop_d;
`ifdef AXIS_MSG_LOOP_EN
            loop_stop_q <= loop_stop_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign wr_drop       = wr_drop_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_msg_source.sv
// Self-checking bench for axis_msg_source: a beat-queue reference model checked every cycle,
// plus directed scenarios with literal expectations. Loop scenario runs when AXIS_MSG_LOOP_EN is defined.
`timescale 1ns/1ps
module tb_axis_msg_source;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef AXIS_MSG_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [AW-1:0]    msg_len = '0;
    logic             start = 1'b0;
    logic             stop_req = 1'b0;
    logic             busy, done, wr_drop;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid, m_axis_tlast;
    logic             m_axis_tready = 1'b1;

    always #5 clk = ~clk;

    axis_msg_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .msg_len       (msg_len),
        .start         (start),
        .stop_req      (stop_req),
        .busy          (busy),
        .done          (done),
        .wr_drop       (wr_drop),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of the beats still owed downstream, built from the model RAM at start.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t            exp_q[$];
    beat_t            mon_b;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             m_busy, m_done, m_drop, m_stop;
    logic [AW-1:0]    m_len;
    logic [WIDTH-1:0] log_data [64];
    logic             log_last [64];
    int               log_cyc  [64];
    int               log_n    = 0;
    int               cyc      = 0;
    int               done_n   = 0;
    int               done_cyc = 0;
    int               drop_n   = 0;

    task automatic push_pass();
        for (int i = 0; i <= int'(m_len); i++) begin
            exp_q.push_back(beat_t'{data: mem[i], last: (i == int'(m_len))});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_drop = 1'b0;
            m_stop = 1'b0;
            m_len  = '0;
            log_n  = 0;
        end else begin
            check("busy", busy, m_busy);
            check("tvalid", m_axis_tvalid, m_busy);
            check("done", done, m_done);
            check("wr_drop", wr_drop, m_drop);
            if (m_busy && exp_q.size() > 0) begin
                check("tdata", m_axis_tdata, exp_q[0].data);
                check("tlast", m_axis_tlast, exp_q[0].last);
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (wr_drop) drop_n++;

            m_done = 1'b0;
            m_drop = wr_en && m_busy;
            if (m_busy) begin
                if (stop_req) m_stop = 1'b1;
                if (m_axis_tready && exp_q.size() > 0) begin
                    mon_b = exp_q.pop_front();
                    if (log_n < 64) begin
                        log_data[log_n] = mon_b.data;
                        log_last[log_n] = mon_b.last;
                        log_cyc[log_n]  = cyc;
                        log_n++;
                    end
                    if (mon_b.last) begin
                        if (LOOP && !m_stop) push_pass();
                        else begin
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                end
            end else begin
                if (wr_en) mem[wr_addr] = wr_data;
                if (start) begin
                    m_busy = 1'b1;
                    m_stop = 1'b0;
                    m_len  = msg_len;
                    log_n  = 0;
                    push_pass();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic load_hello();
        logic [WIDTH-1:0] txt [6];
        txt = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
        for (int i = 0; i < 6; i++) write_word(AW'(i), txt[i]);
    endtask

    task automatic start_msg(input logic [AW-1:0] len);
        msg_len = len;
        start   = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs until both DUT and model are idle, driving tready from a repeating 4-cycle pattern.
    task automatic run_idle(input logic [3:0] pat, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!busy && !m_busy) break;
            m_axis_tready = pat[i % 4];
            step();
        end
        m_axis_tready = 1'b1;
        check(name, (i < budget), 1);
        step();
        step();
    endtask

    task automatic check_hello(input string tag);
        logic [WIDTH-1:0] txt [6];
        txt = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
        check({tag, "_beats"}, log_n, 6);
        for (int i = 0; i < 6; i++) check({tag, "_data"}, log_data[i], txt[i]);
        check({tag, "_last5"}, log_last[5], 1);
        check({tag, "_last4"}, log_last[4], 0);
    endtask

    initial begin
        int d0, dr0, i;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tdata", m_axis_tdata, 0);

        // 1: HELLO\n at full rate
        load_hello();
        d0 = done_n;
        start_msg(4'd5);
        run_idle(4'b1111, 50, "t1_timeout");
        check_hello("t1");
        check("t1_gapless", log_cyc[5] - log_cyc[0], 5);
        check("t1_done_n", done_n - d0, 1);
        check("t1_done_cyc", done_cyc - log_cyc[5], 1);

        // 2: backpressure 1-0-0-1
        start_msg(4'd5);
        run_idle(4'b1001, 100, "t2_timeout");
        check_hello("t2");
        check("t2_stalled", (log_cyc[5] - log_cyc[0]) > 5, 1);

        // 3: single beat, then full RAM
        write_word(4'd0, 8'hA5);
        start_msg(4'd0);
        run_idle(4'b1111, 20, "t3a_timeout");
        check("t3a_beats", log_n, 1);
        check("t3a_data", log_data[0], 8'hA5);
        check("t3a_last", log_last[0], 1);
        for (int k = 0; k < DEPTH; k++) write_word(AW'(k), 8'(8'h10 + k));
        start_msg(4'd15);
        run_idle(4'b1111, 60, "t3b_timeout");
        check("t3b_beats", log_n, 16);
        check("t3b_data15", log_data[15], 8'h1F);
        check("t3b_last15", log_last[15], 1);
        check("t3b_last14", log_last[14], 0);

        // 4: write and start while busy are dropped/ignored; write alongside start lands in beat 0
        load_hello();
        dr0 = drop_n;
        d0  = done_n;
        start_msg(4'd5);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hEE; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        run_idle(4'b1111, 50, "t4a_timeout");
        check_hello("t4a");
        check("t4a_drop_n", drop_n - dr0, 1);
        check("t4a_done_n", done_n - d0, 1);
        start_msg(4'd5);
        run_idle(4'b1111, 50, "t4b_timeout");
        check("t4b_ram2_kept", log_data[2], 8'h4C);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h5A;
        start_msg(4'd5);
        wr_en = 1'b0;
        run_idle(4'b1111, 50, "t4c_timeout");
        check("t4c_bypass", log_data[0], 8'h5A);
        write_word(4'd0, 8'h48);

        // 5: reset while beat 3 is presented
        start_msg(4'd5);
        for (i = 0; i < 50; i++) begin
            if (log_n >= 3) break;
            step();
        end
        check("t5_reach_beat3", log_n, 3);
        rst = 1'b1;
        #1;
        check("t5_tvalid", m_axis_tvalid, 0);
        check("t5_tlast", m_axis_tlast, 0);
        check("t5_busy", busy, 0);
        step();
        step();
        rst = 1'b0;
        step();
        start_msg(4'd2);
        run_idle(4'b1111, 20, "t5_zero_timeout");
        check("t5_ram_cleared", log_data[0], 8'h00);
        load_hello();
        start_msg(4'd5);
        run_idle(4'b1111, 50, "t5_timeout");
        check_hello("t5");

`ifdef AXIS_MSG_LOOP_EN
        // 6: loop mode, stop requested during beat 1 of pass 2
        write_word(4'd0, 8'h41);
        write_word(4'd1, 8'h42);
        write_word(4'd2, 8'h43);
        d0 = done_n;
        start_msg(4'd2);
        for (i = 0; i < 50; i++) begin
            if (log_n >= 4) break;
            step();
        end
        check("t6_reach_pass2", log_n, 4);
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        run_idle(4'b1111, 50, "t6_timeout");
        check("t6_beats", log_n, 6);
        check("t6_last2", log_last[2], 1);
        check("t6_last5", log_last[5], 1);
        check("t6_wrap_data", log_data[3], 8'h41);
        check("t6_gapless", log_cyc[5] - log_cyc[0], 5);
        check("t6_done_n", done_n - d0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
